// File: rtl/parity_pkg.sv
// Shared constants for the parity generator / checker / frame transmitter family.
package parity_pkg;

  // Frame transmitter FSM encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_W     = 8;

  // Parity mode select shared with parity_gen / parity_chk
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_tx_if.sv
// Request/serial-line bundle between the parity source and the frame transmitter.
interface parity_frame_tx_if;
  import parity_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic              p;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (output start, a, p, input tx, busy, done);
  modport slave  (input start, a, p, output tx, busy, done);

endinterface

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, tick on terminal count.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running bit counter, held at zero whenever the transmitter is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, 8 data bits LSB first, parity, stop.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  parity_frame_tx_if.slave   bus
);

  logic [2:0]        state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic              tx_q;
  logic              done_q;
  logic              tick;
  logic              busy_w;

  assign busy_w = (state != ST_IDLE);

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_w),
    .tick (tick)
  );

  // Control FSM; tx is loaded with the value of the state being entered so the line is a clean flop output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_START;
            bit_cnt <= 3'd0;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            tx_q  <= shift[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
              tx_q  <= par;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state  <= ST_IDLE;
            tx_q   <= 1'b1;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // Data capture on frame acceptance, then shift right once per data-bit tick
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && bus.start) begin
      shift <= bus.a;
      par   <= bus.p;
    end else if ((state == ST_DATA) && tick && (bit_cnt != 3'd7)) begin
      shift <= shift >> 1;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_w;
  assign bus.done = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: N=4 and N=1 instances, frame-level model plus literal checks.
module tb_parity_frame_tx;
  import parity_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [2];
  logic [7:0] a_s     [2];
  logic       c_s     [2];
  logic       p_w     [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at cycle %0d: got %0h expected %0h", nm, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int N = (g == 0) ? 4 : 1;

    parity_frame_tx_if bus ();

    // parity_gen stand-in: even parity when c=0, odd when c=1
    assign p_w[g]    = (^a_s[g]) ^ c_s[g];
    assign bus.start = start_s[g];
    assign bus.a     = a_s[g];
    assign bus.p     = p_w[g];

    parity_frame_tx #(.CLKS_PER_BIT(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    // Frame-level reference: position within the frame selects the expected bit
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    int          m_t     = 0;
    logic [10:0] m_frame = '1;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_t    = 0;
      end else if (m_busy) begin
        m_t++;
        if (m_t == FRAME_BITS * N) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_done = 1'b0;
        end
      end else begin
        m_done = 1'b0;
        if (start_s[g]) begin
          m_busy  = 1'b1;
          m_t     = 0;
          m_frame = {1'b1, p_w[g], a_s[g], 1'b0};
        end
      end
    end

    always @(negedge clk) begin
      check("tx",   g, 32'(bus.tx),   32'(m_busy ? m_frame[m_t / N] : 1'b1));
      check("busy", g, 32'(bus.busy), 32'(m_busy));
      check("done", g, 32'(bus.done), 32'(m_done));
    end
  end

  task automatic run_frame(input int g, input int n, input logic [7:0] av, input logic cv, input bit noise);
    a_s[g] = av; c_s[g] = cv; start_s[g] = 1'b1;
    @(negedge clk);
    start_s[g] = 1'b0;
    for (int j = 1; j < FRAME_BITS * n + 1; j++) begin
      if (noise) begin
        start_s[g] = ($urandom_range(0, 3) == 0);
        a_s[g]     = 8'($urandom);
        c_s[g]     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start_s[g] = 1'b0;
  endtask

  logic [10:0] vec;
  int          done_cnt;
  int          done_cyc [4];

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; a_s[g] = 8'h00; c_s[g] = 1'b0;
    end
    #1;
    check("rst_tx",   0, 32'(u[0].bus.tx),   32'd1);
    check("rst_busy", 0, 32'(u[0].bus.busy), 32'd0);
    check("rst_done", 0, 32'(u[0].bus.done), 32'd0);
    check("rst_tx",   1, 32'(u[1].bus.tx),   32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Scenario 1: c=0, a=AA on the N=4 instance
    vec = 11'b10101010100;
    a_s[0] = 8'hAA; c_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int j = 1; j <= 45; j++) begin
      if (j <= 44) begin
        check("s1_tx",   0, 32'(u[0].bus.tx),   32'(vec[(j - 1) / 4]));
        check("s1_busy", 0, 32'(u[0].bus.busy), 32'd1);
        check("s1_done", 0, 32'(u[0].bus.done), 32'd0);
      end else begin
        check("s1_done_pulse", 0, 32'(u[0].bus.done), 32'd1);
        check("s1_busy_end",   0, 32'(u[0].bus.busy), 32'd0);
      end
      if (j < 45) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Scenario 2: a=AB with odd then even parity
    for (int k = 0; k < 2; k++) begin
      a_s[0] = 8'hAB; c_s[0] = (k == 0); start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      for (int j = 1; j <= 45; j++) begin
        if (j == 2)  check("s2_start_bit", 0, 32'(u[0].bus.tx), 32'd0);
        if (j == 6)  check("s2_bit0",      0, 32'(u[0].bus.tx), 32'd1);
        if (j == 38) check("s2_parity",    0, 32'(u[0].bus.tx), (k == 0) ? 32'd0 : 32'd1);
        if (j == 42) check("s2_stop",      0, 32'(u[0].bus.tx), 32'd1);
        if (j < 45) @(negedge clk);
      end
      repeat (2) @(negedge clk);
    end

    // Scenario 3: start pulse and input changes mid-frame are ignored
    a_s[0] = 8'h5A; c_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (9) @(negedge clk);
    a_s[0] = 8'hFF; c_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (20) @(negedge clk);
    a_s[0] = 8'h0F;
    repeat (20) @(negedge clk);
    check("s3_no_second_frame", 0, 32'(u[0].bus.busy), 32'd0);

    // Scenario 4: start held high, frames back-to-back with a 45-cycle period
    done_cnt = 0;
    start_s[0] = 1'b1;
    for (int j = 0; j < 140; j++) begin
      a_s[0] = 8'($urandom); c_s[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (u[0].bus.done && done_cnt < 4) begin
        done_cyc[done_cnt] = cyc;
        done_cnt++;
      end
    end
    start_s[0] = 1'b0;
    check("s4_done_count", 0, 32'(done_cnt >= 2), 32'd1);
    if (done_cnt >= 2) check("s4_period", 0, 32'(done_cyc[1] - done_cyc[0]), 32'd45);
    repeat (50) @(negedge clk);

    // Scenario 5: asynchronous reset during data bit 3
    a_s[0] = 8'hC3; c_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s5_tx_async",   0, 32'(u[0].bus.tx),   32'd1);
    check("s5_busy_async", 0, 32'(u[0].bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(0, 4, 8'h96, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Scenario 6: N=1, a=01, c=0
    vec = 11'b11000000010;
    a_s[1] = 8'h01; c_s[1] = 1'b0; start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      if (j <= 11) check("s6_tx",   1, 32'(u[1].bus.tx),   32'(vec[j - 1]));
      else         check("s6_done", 1, 32'(u[1].bus.done), 32'd1);
      if (j < 12) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Randomized frames with noisy inputs and random gaps on both instances
    for (int i = 0; i < 12; i++) begin
      run_frame(0, 4, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      run_frame(1, 1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter that sits directly downstream of `parity_gen`. It latches an 8-bit data word together with the parity bit that `parity_gen` computes for it, then shifts out one asynchronous-serial frame on a single line. The frame is start bit, 8 data bits LSB first, parity bit, stop bit. It turns the combinational parity result into a timed, handshaked serial stream for the link stage.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range ≥1.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request to send; sampled only while `busy`=0.
- `a` input, 8 bits: data word; the same bus that drives `parity_gen`'s `a`.
- `p` input, 1 bit: parity bit from `parity_gen` for the current `a`/`c`.
- `tx` output, 1 bit: serial line; idles high.
- `busy` output, 1 bit: high while a frame is in flight.
- `done` output, 1 bit: one-cycle pulse marking frame completion.

## Operation
- States:
  - IDLE: `tx`=1, `busy`=0.
  - START: `tx`=0.
  - DATA: `tx`=shift[0].
  - PARITY: `tx`=latched p.
  - STOP: `tx`=1.
- IDLE→START when `start`=1 at a clock edge. On that edge, `a` is captured into the shift register and `p` into a parity flop. Later changes on `a`/`p` do not affect the frame.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. A bit-timer counts 0..`CLKS_PER_BIT`-1 and issues a tick on the terminal count.
- START→DATA on tick.
- In DATA, each tick shifts right. A 3-bit counter moves DATA→PARITY after the 8th bit.
- PARITY→STOP on tick.
- STOP→IDLE on tick, with `done`=1 for the first IDLE cycle.
- `start` while `busy`=1 is ignored; it is neither queued nor does it corrupt the frame.
- `start` in the cycle `done`=1 is accepted (`busy` is already 0), so back-to-back frames have no idle gap beyond that cycle.
- `tx` is registered (no glitches). `busy` is 1 in START/DATA/PARITY/STOP.
- The block does not compute or check parity; it trusts `p`.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0. These take effect immediately on `rst` rising, independent of `clk`.
- Reset mid-frame: the frame is abandoned, the line returns high at once, and no `done` pulse is issued.
- With `start` sampled high at edge k (N=`CLKS_PER_BIT`):
  - `busy`=1 and `tx`=0 from k+1.
  - Data bit i occupies cycles k+1+(1+i)N .. k+(2+i)N.
  - Parity occupies k+1+9N .. k+10N.
  - Stop occupies k+1+10N .. k+11N.
  - `done`=1 and `busy`=0 during cycle k+1+11N.
- Frame length: exactly 11N cycles.
- N=1: every state lasts one cycle; there is no special-case path.
- Throughput: at most one frame per 11N+1 cycles.

## Structure
- Shared package/include `parity_pkg`:
  - state encodings (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - `FRAME_BITS`=11;
  - `DATA_W`=8;
  - parity mode constants `PAR_EVEN`=0 and `PAR_ODD`=1. These are shared with `parity_gen` and `parity_chk`.
- One sub-module: `baud_tick`, the parameterised bit-timer.
  - Inputs: `clk`, `rst`, `en`.
  - Output: `tick`.
  - Restarts from 0 whenever `en` is 0.
- Top-level contents: FSM, shift register, bit counter, parity flop, output flops.

## Test plan
- Bench instantiates `parity_gen` feeding `p`, with N=4.
- Scenario 1: c=0, a=8'hAA, start at cycle 0 → `tx` bits 0,0,1,0,1,0,1,0,1,0,1, each held 4 cycles; `done` pulse at cycle 45; `busy` high cycles 1–44.
- Scenario 2: c=1, a=8'hAB (p=0) → `tx` bits 0,1,1,0,1,0,1,0,1,0,1. Re-run with c=0 → parity bit becomes 1.
- Scenario 3: start a frame, then pulse `start` with a=8'hFF mid-frame. Change `a`/`p` mid-frame → transmitted frame unchanged; no second frame.
- Scenario 4: hold `start` high continuously → frames back-to-back. Second start bit begins the cycle after `done`; period 45 cycles.
- Scenario 5: assert `rst` asynchronously during DATA bit 3 → `tx`=1, `busy`=0 before the next clock edge; no `done`. After release, a new frame is sent correctly.
- Scenario 6: CLKS_PER_BIT=1, a=8'h01, c=0 → `tx` 0,1,0,0,0,0,0,0,0,1,1 on consecutive cycles; `done` at cycle 12.
